// File: rtl/act_out_deskew_writer.sv
// act_out_deskew_writer
//   Realigns the skewed 8-lane activation output (lane i lags lane 0 by i
//   cycles) into whole rows, packs each row into one wide word and writes it
//   to the output BRAM at base_addr + row*addr_stride. done rises once
//   num_rows rows have been written.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   start               one-cycle pulse, latches base/stride/num_rows/mask
//   base_addr           address of row 0
//   addr_stride         address increment per written row
//   num_rows            rows to write in this run
//   validity_mask       per-lane write enable
//   in_data_available   lane-0 row valid
//   inp_data0..7        lane data, lane i valid i cycles after lane 0
//   bram_addr/wdata/we  registered BRAM write port
//   busy, done          run in progress / run complete
module act_out_deskew_writer #(
  parameter int DWIDTH = 8,
  parameter int LANES  = 8,
  parameter int AWIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [AWIDTH-1:0]       base_addr,
  input  logic [AWIDTH-1:0]       addr_stride,
  input  logic [7:0]              num_rows,
  input  logic [LANES-1:0]        validity_mask,
  input  logic                    in_data_available,
  input  logic [DWIDTH-1:0]       inp_data0,
  input  logic [DWIDTH-1:0]       inp_data1,
  input  logic [DWIDTH-1:0]       inp_data2,
  input  logic [DWIDTH-1:0]       inp_data3,
  input  logic [DWIDTH-1:0]       inp_data4,
  input  logic [DWIDTH-1:0]       inp_data5,
  input  logic [DWIDTH-1:0]       inp_data6,
  input  logic [DWIDTH-1:0]       inp_data7,
  output logic [AWIDTH-1:0]       bram_addr,
  output logic [LANES*DWIDTH-1:0] bram_wdata,
  output logic [LANES-1:0]        bram_we,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WRITING = 2'd2,
    DONE    = 2'd3
  } state_t;

  logic [DWIDTH-1:0] lane_in [LANES];
  logic [DWIDTH-1:0] aligned [LANES];

  assign lane_in[0] = inp_data0;
  assign lane_in[1] = inp_data1;
  assign lane_in[2] = inp_data2;
  assign lane_in[3] = inp_data3;
  assign lane_in[4] = inp_data4;
  assign lane_in[5] = inp_data5;
  assign lane_in[6] = inp_data6;
  assign lane_in[7] = inp_data7;

  // Triangular delay line: lane i gets LANES-1-i stages so every lane lines
  // up with the last-arriving lane, which is used straight from the port.
  for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_dly
    localparam int DEPTH = LANES - 1 - gi;
    logic [DWIDTH-1:0] sr_q [DEPTH];
    logic [DWIDTH-1:0] sr_d [DEPTH];

    always_comb begin
      sr_d[0] = lane_in[gi];
      for (int unsigned k = 1; k < DEPTH; k++) begin
        sr_d[k] = sr_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sr_q <= '{default: '0};
      end else begin
        sr_q <= sr_d;
      end
    end

    assign aligned[gi] = sr_q[DEPTH-1];
  end
  assign aligned[LANES-1] = lane_in[LANES-1];

  logic [LANES-2:0] vld_q, vld_d;
  logic             aligned_vld;

  assign vld_d       = {vld_q[LANES-3:0], in_data_available};
  assign aligned_vld = vld_q[LANES-2];

  // Aligned row register, then the FSM decides the write into the output
  // register stage.
  logic [DWIDTH-1:0]       row_q [LANES];
  logic [DWIDTH-1:0]       row_d [LANES];
  logic                    row_vld_q, row_vld_d;

  state_t                  state_q, state_d;
  logic [LANES-1:0]        mask_q, mask_d;
  logic [AWIDTH-1:0]       stride_q, stride_d;
  logic [AWIDTH-1:0]       addr_acc_q, addr_acc_d;
  logic [7:0]              num_rows_q, num_rows_d;
  logic [7:0]              rows_q, rows_d;
  logic [AWIDTH-1:0]       bram_addr_q, bram_addr_d;
  logic [LANES*DWIDTH-1:0] bram_wdata_q, bram_wdata_d;
  logic [LANES-1:0]        bram_we_q, bram_we_d;
  logic                    wr;

  always_comb begin
    row_d     = aligned;
    row_vld_d = aligned_vld;
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    stride_d     = stride_q;
    addr_acc_d   = addr_acc_q;
    num_rows_d   = num_rows_q;
    rows_d       = rows_q;
    bram_addr_d  = '0;
    bram_wdata_d = '0;
    bram_we_d    = '0;

    wr = row_vld_q && ((state_q == ARMED) || (state_q == WRITING));

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mask_d     = validity_mask;
          stride_d   = addr_stride;
          addr_acc_d = base_addr;
          num_rows_d = num_rows;
          rows_d     = '0;
          state_d    = (num_rows == 8'd0) ? DONE : ARMED;
        end
      end
      ARMED: begin
        if (row_vld_q) begin
          state_d = WRITING;
        end
      end
      WRITING: begin
        state_d = WRITING;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Running-sum address: advances on every counted row, even when the
    // mask suppresses all lane enables.
    if (wr) begin
      bram_we_d   = mask_q;
      bram_addr_d = addr_acc_q;
      for (int unsigned i = 0; i < LANES; i++) begin
        bram_wdata_d[i*DWIDTH +: DWIDTH] = mask_q[i] ? row_q[i] : '0;
      end
      addr_acc_d = addr_acc_q + stride_q;
      rows_d     = rows_q + 8'd1;
      if ((rows_q + 8'd1) == num_rows_q) begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q        <= '0;
      row_q        <= '{default: '0};
      row_vld_q    <= 1'b0;
      state_q      <= IDLE;
      mask_q       <= '0;
      stride_q     <= '0;
      addr_acc_q   <= '0;
      num_rows_q   <= '0;
      rows_q       <= '0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      bram_we_q    <= '0;
    end else begin
      vld_q        <= vld_d;
      row_q        <= row_d;
      row_vld_q    <= row_vld_d;
      state_q      <= state_d;
      mask_q       <= mask_d;
      stride_q     <= stride_d;
      addr_acc_q   <= addr_acc_d;
      num_rows_q   <= num_rows_d;
      rows_q       <= rows_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      bram_we_q    <= bram_we_d;
    end
  end

  assign bram_addr  = bram_addr_q;
  assign bram_wdata = bram_wdata_q;
  assign bram_we    = bram_we_q;
  assign busy       = (state_q == ARMED) || (state_q == WRITING);
  assign done       = (state_q == DONE);

endmodule

// File: doc/act_out_deskew_writer.md
Name: act_out_deskew_writer

Overview:
- Consumes the 8-lane activation output, where lane i lags lane 0 by i cycles, and realigns all lanes into one row.
- Packs each aligned row into a single wide word and writes it to the output BRAM at base_addr + row*addr_stride.
- Counts rows and raises done once num_rows rows have been written.
- Sits directly downstream of the activation stage and upstream of the output BRAM port.

Parameters:
- DWIDTH, 8, width of each lane element.
- LANES, 8, number of lanes; the deskew depth is LANES-1.
- AWIDTH, 10, width of the BRAM address.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; latches base_addr, addr_stride, num_rows and validity_mask
- base_addr  in  AWIDTH  address of row 0
- addr_stride  in  AWIDTH  address increment per row
- num_rows  in  8  number of rows to write
- validity_mask  in  LANES  per-lane write enable, latched at start
- in_data_available  in  1  lane-0 row valid, at activation-output timing
- inp_data0..inp_data7  in  DWIDTH each  lane data; lane i is valid i cycles after lane 0
- bram_addr  out  AWIDTH  write address
- bram_wdata  out  LANES*DWIDTH  packed row; lane i occupies bits [i*DWIDTH +: DWIDTH]
- bram_we  out  LANES  per-lane byte write enable
- busy  out  1  high in ARMED or WRITING
- done  out  1  high in DONE

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Delay-line data and valid bits 0; row counter 0.
  - Latched mask, stride and base all 0.
- Deskew:
  - Lane i passes through LANES-1-i data registers; lane 7 has none.
  - in_data_available passes through a LANES-1 deep valid shift register.
  - The shift registers advance every cycle regardless of FSM state.
- Latency:
  - If in_data_available is sampled high at edge E, that row's bram_we/addr/wdata are driven after edge E+LANES (8 edges); a registered output stage follows the aligned point.
  - Outputs hold for exactly one cycle. bram_we returns to 0 on the next edge unless another row follows.
- Gaps: bubbles in in_data_available are preserved. The address advances only on written rows, never on idle cycles.
- Write condition: aligned valid AND FSM in WRITING.
  - bram_we = latched_mask when the condition holds, else 0.
  - Masked-off lanes in bram_wdata are driven to 0.
- Address:
  - Row r writes to (base + r*stride) mod 2^AWIDTH, implemented as a running-sum register with no multiplier.
  - Wrap-around is silent.
- FSM states and transitions:
  - IDLE: on start, latch the configuration; go to DONE if num_rows==0, else to ARMED.
  - ARMED: go to WRITING on the first aligned valid. That same aligned valid produces a write: ARMED behaves as WRITING for this purpose.
  - WRITING: each write increments rows_written. After the write where rows_written reaches num_rows, go to DONE.
  - DONE: done=1 held. Go to ARMED (or straight to DONE if num_rows==0) on the next start, with configuration relatched.
- Boundary conditions:
  - Aligned valids arriving in IDLE or DONE, including rows beyond num_rows, are dropped: no write and no counter change.
  - start while busy is ignored; configuration is not relatched.
  - start in the same cycle as the final write: the final write completes, the FSM enters DONE, and start is ignored.
  - Reset mid-operation: everything clears in one cycle, including in-flight delay-line valids. No spurious writes occur after reset deasserts.
  - validity_mask==0: rows are counted and the address advances, but bram_we stays 0.

Test Plan:
- Basic run: start with base=0x010, stride=1, rows=4, mask=0xFF. Lane i of row r = 16*r+i, with in_data_available high for 4 cycles from edge E. Required: writes at E+8..E+11 to addresses 0x010..0x013; row r wdata bytes = {16r+7,...,16r}; done high after the 4th write.
- Bubbles and stride: rows=3, stride=5, base=0x3FC, with in_data_available pattern 1,0,1,1. Required: writes to 0x3FC, 0x001 (wrap), 0x006, with the one-cycle gap preserved in bram_we.
- Mask: mask=0x0F, rows=2. Required: bram_we=0x0F on both writes and upper four lanes of bram_wdata = 0.
- Overflow and restart:
  - rows=2 with 4 valid rows supplied. Required: exactly 2 writes; done held; rows 3-4 dropped.
  - A new start with rows=1 then writes 1 row at the new base.
- Corner cases:
  - start with rows=0 → done the next cycle and no writes.
  - A second start while busy → ignored; the original num_rows is honoured.
- Reset mid-run: assert reset 3 cycles after in_data_available while rows are in flight. Required: no bram_we after reset; busy=done=0; a subsequent run behaves as in the basic run.
